// File: rtl/mio_pkg.sv
// ---------------------------------------------------------------------------
// mio_pkg
//   Shared types and helpers for the memory/IO bus arbiter.
//   - state_t : sequencer states (IDLE, ACCESS, DONE)
//   - op_t    : latched command operation (NOP, READ, WRITE)
//   - VRAM_TOP3 / IO_TOP3 : address[31:29] patterns of the slow regions
//   - is_slow()   : true when an address falls in VRAM or IO space
//   - decode_op() : maps the we/re request pair onto an op_t
// ---------------------------------------------------------------------------
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // VRAM occupies c000_0000-dfff_ffff, IO occupies a000_0000-bfff_ffff.
    localparam logic [2:0] VRAM_TOP3 = 3'b110;
    localparam logic [2:0] IO_TOP3   = 3'b101;

    function automatic logic is_slow(input logic [31:0] addr);
        return (addr[31:29] == VRAM_TOP3) || (addr[31:29] == IO_TOP3);
    endfunction

    // A write request dominates a simultaneous read request.
    function automatic op_t decode_op(input logic we, input logic re);
        op_t op;
        if (we) begin
            op = OP_WRITE;
        end else if (re) begin
            op = OP_READ;
        end else begin
            op = OP_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/mio_rr_pick.sv
// ---------------------------------------------------------------------------
// mio_rr_pick
//   Purely combinational two-way picker used by mio_arbiter in IDLE.
//   Ports:
//     req[1:0]   in  : request vector, bit 0 = M0, bit 1 = M1
//     last_gnt   in  : master that completed the most recent transaction
//     fixed_prio in  : 1 = M0 always wins a conflict, 0 = round-robin
//     valid      out : at least one request present
//     gnt_id     out : index of the chosen master
// ---------------------------------------------------------------------------
module mio_rr_pick (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_prio,
    output logic       valid,
    output logic       gnt_id
);

    always_comb begin
        valid  = |req;
        gnt_id = 1'b0;
        case (req)
            2'b10:   gnt_id = 1'b1;
            // Conflict: either fixed M0 priority, or hand the bus to the
            // master that did not own it last time.
            2'b11:   gnt_id = fixed_prio ? 1'b0 : ~last_gnt;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/mio_arbiter.sv
// ---------------------------------------------------------------------------
// mio_arbiter
//   Two-master arbiter and sequencer in front of the memory/IO bus decoder.
//   M0 is the CPU, M1 the DMA/text-scroll engine. One command is latched per
//   transaction, the bus strobes are driven in the last of 1+wait ACCESS
//   cycles, and the owning master gets a one-cycle ack in DONE.
//
//   Parameters:
//     WAIT_FAST  : extra ACCESS cycles for ordinary addresses
//     WAIT_SLOW  : extra ACCESS cycles for VRAM / IO addresses
//     FIXED_PRIO : 1 = M0 wins every conflict, 0 = round-robin
//
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     mX_req/addr/wdata/we/re  : master X request and command (X = 0, 1)
//     mX_ack                   : master X one-cycle completion pulse
//     rdata                    : read data, updated only by READ transactions
//     mem_a, d_t_mem           : bus address / write data (0 outside ACCESS)
//     wmem, rmem               : bus write / read strobes (final ACCESS cycle)
//     d_f_mem                  : bus read data
//     busy                     : high in ACCESS and DONE
//     gnt_id                   : master owning the current/last transaction
// ---------------------------------------------------------------------------
module mio_arbiter
    import mio_pkg::*;
#(
    parameter int WAIT_FAST  = 0,
    parameter int WAIT_SLOW  = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_re,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_re,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] rdata,
    output logic [31:0] mem_a,
    output logic [31:0] d_t_mem,
    output logic        wmem,
    output logic        rmem,
    input  logic [31:0] d_f_mem,
    output logic        busy,
    output logic        gnt_id
);

    localparam int WAIT_MAX = (WAIT_FAST > WAIT_SLOW) ? WAIT_FAST : WAIT_SLOW;
    localparam int WCW      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [WCW-1:0] WAIT_FAST_W = WCW'(WAIT_FAST);
    localparam logic [WCW-1:0] WAIT_SLOW_W = WCW'(WAIT_SLOW);
    localparam logic [WCW-1:0] WAIT_ONE_W  = WCW'(1);

    state_t         state_q,    state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]    addr_q,     addr_d;
    logic [31:0]    wdata_q,    wdata_d;
    op_t            op_q,       op_d;
    logic           gnt_id_q,   gnt_id_d;
    logic           last_gnt_q, last_gnt_d;
    logic [31:0]    rdata_q,    rdata_d;

    logic           pick_valid;
    logic           pick_gnt;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic           sel_we;
    logic           sel_re;

    mio_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_gnt   (last_gnt_q),
        .fixed_prio (FIXED_PRIO != 0),
        .valid      (pick_valid),
        .gnt_id     (pick_gnt)
    );

    // Command of whichever master the picker selected this cycle.
    always_comb begin
        sel_addr  = pick_gnt ? m1_addr  : m0_addr;
        sel_wdata = pick_gnt ? m1_wdata : m0_wdata;
        sel_we    = pick_gnt ? m1_we    : m0_we;
        sel_re    = pick_gnt ? m1_re    : m0_re;
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_id_d   = pick_gnt;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    op_d       = decode_op(sel_we, sel_re);
                    wait_cnt_d = is_slow(sel_addr) ? WAIT_SLOW_W : WAIT_FAST_W;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // wait_cnt==0 marks the strobe cycle; read data is captured
                // at its closing edge so it is stable by the ack.
                if (wait_cnt_q == '0) begin
                    if (op_q == OP_READ) begin
                        rdata_d = d_f_mem;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_ONE_W;
                end
            end
            ST_DONE: begin
                // Round-robin history only advances on completed
                // transactions, so an abandoned access does not count.
                last_gnt_d = gnt_id_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_NOP;
            gnt_id_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs are decoded from registered state only, so an asynchronous
    // reset clears the strobes and bus lines without waiting for a clock.
    logic in_access;
    logic final_cycle;
    logic in_done;

    always_comb begin
        in_access   = (state_q == ST_ACCESS);
        final_cycle = in_access && (wait_cnt_q == '0);
        in_done     = (state_q == ST_DONE);

        mem_a   = in_access ? addr_q  : '0;
        d_t_mem = in_access ? wdata_q : '0;
        wmem    = final_cycle && (op_q == OP_WRITE);
        rmem    = final_cycle && (op_q == OP_READ);
        m0_ack  = in_done && !gnt_id_q;
        m1_ack  = in_done &&  gnt_id_q;
        busy    = in_access || in_done;
        gnt_id  = gnt_id_q;
        rdata   = rdata_q;
    end

endmodule

// File: tb/tb_mio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mio_arbiter
//   Directed bench for mio_arbiter (WAIT_FAST=0, WAIT_SLOW=2, round-robin)
//   plus a FIXED_PRIO=1 instance exercised in the conflict test.
//   A transaction-timeline model predicts every output of the main instance
//   each cycle; directed steps add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mio_arbiter;

    localparam int WF = 0;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m0_re, m1_req, m1_we, m1_re;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, d_f_mem;
    logic        m0_ack, m1_ack, wmem, rmem, busy, gnt_id;
    logic [31:0] rdata, mem_a, d_t_mem;

    logic        f_m0_req, f_m1_req;
    logic [31:0] f_m0_addr, f_m1_addr;
    logic        f_m0_ack, f_m1_ack, f_wmem, f_rmem, f_busy, f_gnt_id;
    logic [31:0] f_rdata, f_mem_a, f_d_t_mem;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mio_arbiter #(.WAIT_FAST(WF), .WAIT_SLOW(WS), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_re(m0_re),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_re(m1_re),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata), .mem_a(mem_a), .d_t_mem(d_t_mem),
        .wmem(wmem), .rmem(rmem), .d_f_mem(d_f_mem), .busy(busy), .gnt_id(gnt_id)
    );

    mio_arbiter #(.WAIT_FAST(WF), .WAIT_SLOW(WS), .FIXED_PRIO(1)) u_fix (
        .clk(clk), .rst(rst),
        .m0_req(f_m0_req), .m0_addr(f_m0_addr), .m0_wdata(32'h0), .m0_we(1'b0), .m0_re(1'b1),
        .m1_req(f_m1_req), .m1_addr(f_m1_addr), .m1_wdata(32'h0), .m1_we(1'b0), .m1_re(1'b1),
        .m0_ack(f_m0_ack), .m1_ack(f_m1_ack), .rdata(f_rdata), .mem_a(f_mem_a), .d_t_mem(f_d_t_mem),
        .wmem(f_wmem), .rmem(f_rmem), .d_f_mem(d_f_mem), .busy(f_busy), .gnt_id(f_gnt_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: one in-flight transaction described by owner, command and its
    // age (cycles since grant). Ages 1..len are ACCESS cycles, len+1 is the
    // ack cycle; len = 1 + wait derived from the address range.
    // ------------------------------------------------------------------
    bit          m_active, m_master, m_last, m_gnt, m_win;
    int          m_age, m_len, m_op;      // op: 0 nop, 1 read, 2 write
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic bit addr_slow(input logic [31:0] a);
        return (a >= 32'hA000_0000) && (a <= 32'hDFFF_FFFF);
    endfunction

    task automatic m_reset();
        m_active = 1'b0; m_last = 1'b1; m_gnt = 1'b0;
        m_age = 0; m_len = 0; m_op = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else if (!m_active) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) m_win = !m_last;
                    else                  m_win = m1_req;
                    m_master = m_win;
                    m_gnt    = m_win;
                    m_addr   = m_win ? m1_addr  : m0_addr;
                    m_wdata  = m_win ? m1_wdata : m0_wdata;
                    if (m_win ? m1_we : m0_we)      m_op = 2;
                    else if (m_win ? m1_re : m0_re) m_op = 1;
                    else                            m_op = 0;
                    m_len    = 1 + (addr_slow(m_addr) ? WS : WF);
                    m_age    = 1;
                    m_active = 1'b1;
                end
            end else if (m_age <= m_len) begin
                if (m_age == m_len && m_op == 1) m_rdata = d_f_mem;
                m_age++;
            end else begin
                m_last   = m_master;
                m_active = 1'b0;
            end
        end
    end

    // Per-cycle comparison of the main instance against the model.
    initial begin
        bit in_acc, fin, dn;
        forever begin
            @(negedge clk);
            in_acc = m_active && (m_age <= m_len);
            fin    = in_acc && (m_age == m_len);
            dn     = m_active && (m_age == m_len + 1);
            chk("mdl_m0_ack",  32'(m0_ack),  32'(dn && !m_master));
            chk("mdl_m1_ack",  32'(m1_ack),  32'(dn &&  m_master));
            chk("mdl_wmem",    32'(wmem),    32'(fin && m_op == 2));
            chk("mdl_rmem",    32'(rmem),    32'(fin && m_op == 1));
            chk("mdl_mem_a",   mem_a,        in_acc ? m_addr  : 32'h0);
            chk("mdl_d_t_mem", d_t_mem,      in_acc ? m_wdata : 32'h0);
            chk("mdl_busy",    32'(busy),    32'(m_active));
            chk("mdl_gnt_id",  32'(gnt_id),  32'(m_gnt));
            chk("mdl_rdata",   rdata,        m_rdata);
            if (m0_ack || m1_ack)
                $display("txn cycle %0d m%0d addr %h op %0d rdata %h", cyc, gnt_id, m_addr, m_op, rdata);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change on negedges (or just after).
    // ------------------------------------------------------------------
    initial begin
        m0_req = 0; m0_we = 0; m0_re = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_re = 0; m1_addr = 0; m1_wdata = 0;
        d_f_mem = 0;
        f_m0_req = 0; f_m1_req = 0; f_m0_addr = 32'h300; f_m1_addr = 32'h400;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_gnt", 32'(gnt_id), 0);
        chk("rst_ack", 32'({m0_ack, m1_ack}), 0);
        rst = 0;

        // M0 fast write
        m0_addr = 32'h0000_0800; m0_wdata = 32'hDEAD_BEEF; m0_we = 1; m0_req = 1;
        @(negedge clk);
        chk("t1_wmem", 32'(wmem), 1);
        chk("t1_rmem", 32'(rmem), 0);
        chk("t1_mem_a", mem_a, 32'h0000_0800);
        chk("t1_d_t_mem", d_t_mem, 32'hDEAD_BEEF);
        chk("t1_noack", 32'(m0_ack), 0);
        @(negedge clk);
        chk("t1_ack", 32'(m0_ack), 1);
        chk("t1_wmem_off", 32'(wmem), 0);
        m0_req = 0; m0_we = 0;
        @(negedge clk);

        // M1 slow read of VRAM
        m1_addr = 32'hC000_0010; m1_re = 1; d_f_mem = 32'h41; m1_req = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                chk("t2_mem_a", mem_a, 32'hC000_0010);
                chk("t2_rmem", 32'(rmem), 32'(k == 3));
                chk("t2_noack", 32'(m1_ack), 0);
            end else begin
                chk("t2_ack", 32'(m1_ack), 1);
                chk("t2_rdata", rdata, 32'h0000_0041);
                m1_req = 0; m1_re = 0;
            end
        end
        @(negedge clk);

        // Continuous conflict from reset: round-robin vs fixed priority
        #2 rst = 1;
        @(negedge clk);
        rst = 0;
        m0_addr = 32'h100; m0_wdata = 32'h1111_1111; m0_we = 1; m0_req = 1;
        m1_addr = 32'h200; m1_re = 1; m1_req = 1;
        d_f_mem = 32'h2222_2222;
        f_m0_req = 1; f_m1_req = 1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("t3_ack0", 32'(m0_ack), 32'(k == 2 || k == 8));
            chk("t3_ack1", 32'(m1_ack), 32'(k == 5 || k == 11));
            chk("t3_fix_ack0", 32'(f_m0_ack), 32'((k % 3) == 2));
            chk("t3_fix_ack1", 32'(f_m1_ack), 0);
            chk("t3_fix_busy", 32'(f_busy), 32'((k % 3) != 0));
            chk("t3_fix_rmem", 32'(f_rmem), 32'((k % 3) == 1));
            chk("t3_fix_mem_a", f_mem_a, ((k % 3) == 1) ? 32'h300 : 32'h0);
            chk("t3_fix_misc", {f_d_t_mem[29:0], f_wmem, f_gnt_id}, 0);
            if (k == 11) begin
                chk("t3_fix_rdata", f_rdata, 32'h2222_2222);
                m0_req = 0; m0_we = 0; m1_req = 0; m1_re = 0;
                f_m0_req = 0; f_m1_req = 0;
            end
        end
        @(negedge clk);

        // M0 read with req dropped after one cycle
        d_f_mem = 32'h1234_5678; m0_addr = 32'h10; m0_re = 1; m0_req = 1;
        @(negedge clk);
        chk("t4_rmem", 32'(rmem), 1);
        m0_req = 0; m0_re = 0;
        @(negedge clk);
        chk("t4_ack", 32'(m0_ack), 1);
        chk("t4_rdata", rdata, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_idle", 32'({busy, m0_ack}), 0);
        end

        // NOP, then write with we=re=1
        d_f_mem = 32'h9999_9999; m0_addr = 32'h20; m0_req = 1;
        @(negedge clk);
        chk("t6_nop_strobes", 32'({wmem, rmem}), 0);
        chk("t6_nop_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t6_nop_ack", 32'(m0_ack), 1);
        chk("t6_nop_rdata", rdata, 32'h1234_5678);
        m0_req = 0;
        @(negedge clk);
        m1_addr = 32'h30; m1_wdata = 32'hCAFE_F00D; m1_we = 1; m1_re = 1; m1_req = 1;
        @(negedge clk);
        chk("t6_wr_wmem", 32'(wmem), 1);
        chk("t6_wr_rmem", 32'(rmem), 0);
        chk("t6_wr_data", d_t_mem, 32'hCAFE_F00D);
        @(negedge clk);
        chk("t6_wr_ack", 32'(m1_ack), 1);
        chk("t6_wr_rdata", rdata, 32'h1234_5678);
        m1_req = 0; m1_we = 0; m1_re = 0;
        @(negedge clk);

        // Async reset during slow ACCESS cycle 2
        m1_addr = 32'hA000_0004; m1_wdata = 32'h55; m1_we = 1; m1_req = 1;
        @(negedge clk);
        chk("t5_acc1", mem_a, 32'hA000_0004);
        @(negedge clk);
        chk("t5_acc2_busy", 32'(busy), 1);
        #2 rst = 1;
        #1;
        chk("t5_async_mem_a", mem_a, 0);
        chk("t5_async_strobes", 32'({wmem, rmem}), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_ack", 32'({m0_ack, m1_ack}), 0);
        @(negedge clk);
        chk("t5_rst_ack", 32'({m0_ack, m1_ack}), 0);
        rst = 0;
        @(negedge clk);
        chk("t5_m1_gnt", 32'(gnt_id), 1);
        chk("t5_m1_mem_a", mem_a, 32'hA000_0004);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("t5_m1_ack", 32'(m1_ack), 32'(k == 4));
            chk("t5_m1_wmem", 32'(wmem), 32'(k == 3));
        end
        m1_req = 0; m1_we = 0;
        @(negedge clk);
        #2 rst = 1;
        m0_addr = 32'h40; m0_wdata = 32'h77; m0_we = 1; m0_req = 1;
        m1_addr = 32'h50; m1_re = 1; m1_req = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("t5_both_gnt", 32'(gnt_id), 0);
        chk("t5_both_mem_a", mem_a, 32'h40);
        @(negedge clk);
        chk("t5_both_ack0", 32'(m0_ack), 1);
        m0_req = 0; m0_we = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t5_then_ack1", 32'(m1_ack), 32'(k == 3));
        end
        m1_req = 0; m1_re = 0;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
